// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_pkg
//  Description : State encoding and sign helpers shared by the sequential
//                divider. Helpers work on MAX_W bits; callers truncate.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    localparam int MAX_W = 64;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_CALC  = 2'd1;
    localparam state_t S_FIXUP = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
        return ~x + MAX_W'(1);
    endfunction

    // x must arrive sign-extended to MAX_W so the negation truncates correctly
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                                 input logic             neg);
        return neg ? twos_neg(x) : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_if
//  Description : Start/done handshake and operand/result bus of the divider.
//                div_zero exists only when DIV_ZERO_TRAP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   z_out;
`ifdef DIV_ZERO_TRAP_EN
    logic                 div_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, z_out, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, z_out, div_zero
    );
`else
    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, z_out
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, z_out
    );
`endif
endinterface
`default_nettype wire

// File: rtl/seq_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_step
//  Description : One combinational restoring-division iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH:0]   i_rem,
    input  wire logic             i_bit,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH:0]   o_rem,
    output logic                  o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;

    // One extra bit of headroom so the trial's sign bit is unambiguous
    assign w_shift = {i_rem, i_bit};
    assign w_trial = w_shift - {2'b00, i_divisor};
    assign o_qbit  = ~w_trial[WIDTH+1];
    assign o_rem   = o_qbit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle radix-2 restoring signed/unsigned divider,
//                result {remainder, quotient}. Option: DIV_ZERO_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
import seq_divider_pkg::*;

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic     Clock,
    input  wire logic     Clear,
    seq_divider_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_a_mag;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_zero;
    logic [2*WIDTH-1:0] r_z;
`ifdef DIV_ZERO_TRAP_EN
    logic               r_dz;
`endif

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_zero;
    logic [WIDTH:0]     w_step_rem;
    logic               w_step_q;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_neg_a  = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_neg_b  = bus.is_signed & bus.divisor[WIDTH-1];
    assign w_a_mag  = WIDTH'(abs_val(MAX_W'($signed(bus.dividend)), w_neg_a));
    assign w_b_mag  = WIDTH'(abs_val(MAX_W'($signed(bus.divisor)), w_neg_b));
    assign w_b_zero = (bus.divisor == '0);

    seq_div_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    // Zero divisor: quotient all ones, remainder is the raw dividend, which
    // re-applying the dividend sign to its magnitude reproduces exactly.
    assign w_r_mag = r_zero ? r_a_mag : r_rem[WIDTH-1:0];
    assign w_q_fix = r_zero  ? '1
                   : r_neg_q ? WIDTH'(twos_neg(MAX_W'(r_quo))) : r_quo;
    assign w_r_fix = r_neg_r ? WIDTH'(twos_neg(MAX_W'(w_r_mag))) : w_r_mag;

    // State register
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
`ifdef DIV_ZERO_TRAP_EN
                    w_next = w_b_zero ? S_FIXUP : S_CALC;
`else
                    w_next = S_CALC;
`endif
                end
            end
            S_CALC:  if (r_cnt == '0) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy = (r_state != S_IDLE);
        bus.done = (r_state == S_DONE);
    end

    assign bus.z_out = r_z;
`ifdef DIV_ZERO_TRAP_EN
    assign bus.div_zero = r_dz;
`endif

    // Datapath: operand capture, iteration and sign fixup
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_a_mag <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
            r_z     <= '0;
`ifdef DIV_ZERO_TRAP_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_a_mag <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_zero  <= w_b_zero;
                    end
                end
                S_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_q};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIXUP: begin
                    r_z  <= {w_r_fix, w_q_fix};
`ifdef DIV_ZERO_TRAP_EN
                    r_dz <= r_zero;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
